pkt_ingress_framer: RTL
=======================

Name: pkt_ingress_framer

Overview:
- Ingress stage directly upstream of packet_proc.
- Accepts a per-packet length descriptor plus a valid/ready word stream, and drives packet_proc's enqueue port (enq_req, in_sop, in_eop, pck_len_valid, pck_len_i, wr_data_i).
- Guarantees packet_proc's protocol rules:
  - no enqueue while full or overflow;
  - in_sop and in_eop never asserted together;
  - no packet length below 2.
- Filters malformed packets, truncates overlong ones, and keeps status counters.

Parameters:
DATA_WIDTH, 32, data word width
PCK_LEN, 12, width of the packet-length field
MAX_LEN, 2048, largest accepted packet length in words (must be <= 2**PCK_LEN-1)
CNT_WIDTH, 16, width of the status counters

Ports:
clk  in  1  clock
sw_rst  in  1  synchronous reset, active-high
hdr_valid  in  1  length descriptor valid
hdr_ready  out  1  descriptor accepted when hdr_valid && hdr_ready
hdr_len  in  PCK_LEN  packet length in words
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid && s_ready
s_data  in  DATA_WIDTH  stream word
s_last  in  1  last word of the source packet
pck_proc_full  in  1  packet_proc full
pck_proc_overflow  in  1  packet_proc overflow
enq_req  out  1  enqueue strobe to packet_proc
in_sop  out  1  first word of packet
in_eop  out  1  last word of packet
wr_data_o  out  DATA_WIDTH  enqueued word (to wr_data_i)
pck_len_valid  out  1  pck_len_o valid (with in_sop)
pck_len_o  out  PCK_LEN  enqueued packet length (to pck_len_i)
pkt_cnt  out  CNT_WIDTH  packets forwarded
drop_cnt  out  CNT_WIDTH  descriptors rejected (length out of range)
len_err_cnt  out  CNT_WIDTH  packets with length/s_last mismatch

Behaviour:
- stall = pck_proc_full || pck_proc_overflow, sampled combinationally in the same cycle.
- Enqueue path is combinational from s_* (0-cycle latency): wr_data_o = s_data.
- FSM states:
  - IDLE:
    - hdr_ready=1, s_ready=0.
    - On hdr handshake, latch len=hdr_len.
    - len<2 or len>MAX_LEN: go to DROP, drop_cnt++.
    - Otherwise: go to SOP, word counter cnt=0.
  - SOP:
    - s_ready = !stall.
    - enq_req = in_sop = pck_len_valid = s_valid && !stall; pck_len_o = len.
    - On accept: cnt=1, go to BODY.
    - If s_last on the SOP word: enqueue it as sop only, go to TERM.
  - BODY:
    - s_ready = !stall; enq_req = s_valid && !stall.
    - in_eop = enq_req && (cnt==len-1 || s_last). On every accept, cnt++.
    - Eop with s_last and cnt==len-1: pkt_cnt++, go to IDLE.
    - Eop with s_last and cnt<len-1 (short): len_err_cnt++, pkt_cnt++, go to IDLE.
    - Eop at cnt==len-1 without s_last (long): len_err_cnt++, pkt_cnt++, go to DROP.
  - TERM (s_last seen on the sop word):
    - s_ready=0.
    - When !stall: enq_req=in_eop=1, wr_data_o=0 (pad word); len_err_cnt++, pkt_cnt++, go to IDLE.
  - DROP:
    - s_ready=1, enq_req=0; discard words until an accepted s_last, then go to IDLE.
    - If entered from IDLE via drop, the packet's words are discarded likewise.
- hdr_ready=0 in all states except IDLE.
- in_sop and in_eop are never both 1; in_eop, in_sop and pck_len_valid are never 1 without enq_req.
- pck_len_valid/pck_len_o are valid only on the sop cycle; pck_len_o=0 otherwise.
- Stall mid-packet freezes state and cnt; no word is lost or duplicated.
- Counters saturate at all-ones.
- Reset (sw_rst=1, any state, including mid-packet):
  - state=IDLE, cnt=0, len=0;
  - all counters 0;
  - enq_req, in_sop, in_eop, pck_len_valid, s_ready = 0; pck_len_o=0;
  - hdr_ready=0 during reset, 1 the cycle after.
  - A partially enqueued packet is abandoned; packet_proc is reset by the same sw_rst.

Test Plan:
- hdr_len=4, 4 words 0xA0..0xA3, s_last on 4th, no stall -> enq_req 4 cycles; in_sop+pck_len_valid+pck_len_o=4 on 0xA0; in_eop on 0xA3; pkt_cnt=1.
- hdr_len=1, then 1 word with s_last -> no enq_req; s_ready=1 until s_last; drop_cnt=1. Repeat with hdr_len=MAX_LEN+1 and 3 words -> drop_cnt=2.
- hdr_len=6, 5 words, s_last on 5th -> in_eop on 5th word; len_err_cnt=1; pkt_cnt=1.
- hdr_len=3, 5 words, s_last on 5th -> in_eop on 3rd word; words 4-5 consumed and not enqueued; len_err_cnt=1.
- hdr_len=8, pck_proc_full=1 for 3 cycles after word 2 -> enq_req=0 and s_ready=0 during stall; all 8 words enqueued in order exactly once.
- sw_rst=1 for one cycle after word 2 of an 8-word packet -> next cycle all outputs 0, counters 0; a new hdr_len=2 packet then forwards normally with pck_len_o=2.

Source files
------------

// File: rtl/pkt_ingress_framer_if.sv
// Ingress bus for pkt_ingress_framer: length descriptor, word stream and the
// packet_proc enqueue port. slave is the framer's view, master the neighbours'.
interface pkt_ingress_framer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PCK_LEN    = 12
);
  logic                  hdr_valid;
  logic                  hdr_ready;
  logic [PCK_LEN-1:0]    hdr_len;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  pck_proc_full;
  logic                  pck_proc_overflow;
  logic                  enq_req;
  logic                  in_sop;
  logic                  in_eop;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  pck_len_valid;
  logic [PCK_LEN-1:0]    pck_len_o;

  modport slave (
    input  hdr_valid, hdr_len, s_valid, s_data, s_last, pck_proc_full, pck_proc_overflow,
    output hdr_ready, s_ready, enq_req, in_sop, in_eop, wr_data_o, pck_len_valid, pck_len_o
  );

  modport master (
    output hdr_valid, hdr_len, s_valid, s_data, s_last, pck_proc_full, pck_proc_overflow,
    input  hdr_ready, s_ready, enq_req, in_sop, in_eop, wr_data_o, pck_len_valid, pck_len_o
  );
endinterface

// File: rtl/pkt_ingress_framer.sv
// Frames a length descriptor plus word stream into packet_proc enqueue beats,
// filtering bad lengths, fixing length/s_last mismatches and counting events.
module pkt_ingress_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int PCK_LEN    = 12,
  parameter int MAX_LEN    = 2048,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 sw_rst,
  pkt_ingress_framer_if.slave  bus,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] len_err_cnt
);
  typedef enum logic [2:0] {IDLE, SOP, BODY, TERM, DROP} state_t;

  localparam logic [PCK_LEN-1:0] MIN_L = PCK_LEN'(2);
  localparam logic [PCK_LEN-1:0] MAX_L = PCK_LEN'(MAX_LEN);

  state_t                state_q, state_d;
  logic [PCK_LEN-1:0]    len_q, len_d;
  logic [PCK_LEN-1:0]    cnt_q, cnt_d;
  logic                  stall, at_end;
  logic                  hdr_rdy, s_rdy, enq, sop, eop, plv, pad;
  logic                  pkt_inc, drop_inc, err_inc;
  logic [DATA_WIDTH-1:0] wr_data;

  assign stall  = bus.pck_proc_full | bus.pck_proc_overflow;
  assign at_end = (cnt_q == len_q - PCK_LEN'(1));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hdr_rdy  = 1'b0;
    s_rdy    = 1'b0;
    enq      = 1'b0;
    sop      = 1'b0;
    eop      = 1'b0;
    plv      = 1'b0;
    pad      = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    // All handshakes and strobes are held low while reset is asserted.
    if (!sw_rst) begin
      unique case (state_q)
        IDLE: begin
          hdr_rdy = 1'b1;
          if (bus.hdr_valid) begin
            len_d = bus.hdr_len;
            cnt_d = '0;
            if (bus.hdr_len < MIN_L || bus.hdr_len > MAX_L) begin
              state_d  = DROP;
              drop_inc = 1'b1;
            end else begin
              state_d = SOP;
            end
          end
        end
        SOP: begin
          s_rdy = !stall;
          enq   = bus.s_valid && !stall;
          sop   = enq;
          plv   = enq;
          if (enq) begin
            cnt_d   = PCK_LEN'(1);
            // A one-word source packet cannot carry eop on its sop beat.
            state_d = bus.s_last ? TERM : BODY;
          end
        end
        BODY: begin
          s_rdy = !stall;
          enq   = bus.s_valid && !stall;
          eop   = enq && (at_end || bus.s_last);
          if (enq) begin
            cnt_d = cnt_q + PCK_LEN'(1);
            if (bus.s_last) begin
              pkt_inc = 1'b1;
              err_inc = !at_end;
              state_d = IDLE;
            end else if (at_end) begin
              pkt_inc = 1'b1;
              err_inc = 1'b1;
              state_d = DROP;
            end
          end
        end
        TERM: begin
          if (!stall) begin
            enq     = 1'b1;
            eop     = 1'b1;
            pad     = 1'b1;
            pkt_inc = 1'b1;
            err_inc = 1'b1;
            state_d = IDLE;
          end
        end
        DROP: begin
          s_rdy = 1'b1;
          if (bus.s_valid && bus.s_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign wr_data           = pad ? '0 : bus.s_data;
  assign bus.wr_data_o     = wr_data;
  assign bus.hdr_ready     = hdr_rdy;
  assign bus.s_ready       = s_rdy;
  assign bus.enq_req       = enq;
  assign bus.in_sop        = sop;
  assign bus.in_eop        = eop;
  assign bus.pck_len_valid = plv;
  assign bus.pck_len_o     = plv ? len_q : '0;

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      pkt_cnt     <= '0;
      drop_cnt    <= '0;
      len_err_cnt <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      // Status counters stick at all-ones instead of wrapping.
      if (pkt_inc && pkt_cnt != '1)      pkt_cnt     <= pkt_cnt + 1'b1;
      if (drop_inc && drop_cnt != '1)    drop_cnt    <= drop_cnt + 1'b1;
      if (err_inc && len_err_cnt != '1)  len_err_cnt <= len_err_cnt + 1'b1;
    end
  end
endmodule
